// File: rtl/mac_operand_sequencer.sv
// Streams one neuron's activation x weight terms into an external negedge MAC and returns the sum.
// Optional RELU_EN clamps negative sums to zero when the result is captured.
module mac_operand_sequencer #(
    parameter int ADDR_W = 4,
    parameter int NEUR_W = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [NEUR_W-1:0]        neuron_idx,
    output logic                     busy,
    output logic [ADDR_W-1:0]        act_addr,
    input  logic signed [15:0]       act_data,
    output logic [NEUR_W+ADDR_W-1:0] wt_addr,
    input  logic signed [7:0]        wt_data,
    output logic signed [15:0]       mac_op1,
    output logic signed [7:0]        mac_op2,
    output logic                     mac_clear,
    input  logic signed [15:0]       mac_out,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic signed [15:0]       res_data,
    output logic [NEUR_W-1:0]        res_idx
);

    typedef enum logic [2:0] {IDLE, FETCH, STREAM, DRAIN, HOLD} state_t;

    localparam logic [ADDR_W-1:0] LAST_TERM = '1;

    state_t            state;
    logic [NEUR_W-1:0] idx_p0;
    logic [ADDR_W-1:0] term_p0;
    logic              vld_p1;

    function automatic logic signed [15:0] shape_result(input logic signed [15:0] sum);
`ifdef RELU_EN
        return (sum < 16'sd0) ? 16'sd0 : sum;
`else
        return sum;
`endif
    endfunction

    // Stage p0: registered memory addresses
    assign act_addr = term_p0;
    assign wt_addr  = {idx_p0, term_p0};

    // Stage p1: memory data returns; gated so the free-running MAC adds zero between neurons
    assign mac_op1 = vld_p1 ? act_data : 16'sd0;
    assign mac_op2 = vld_p1 ? wt_data  : 8'sd0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            idx_p0    <= '0;
            term_p0   <= '0;
            vld_p1    <= 1'b0;
            mac_clear <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= FETCH;
                        busy    <= 1'b1;
                        idx_p0  <= neuron_idx;
                        term_p0 <= '0;
                    end
                end
                FETCH: begin
                    vld_p1    <= 1'b1;
                    mac_clear <= 1'b1;
                    if (term_p0 == LAST_TERM) begin
                        state <= DRAIN;
                    end else begin
                        state   <= STREAM;
                        term_p0 <= term_p0 + 1'b1;
                    end
                end
                STREAM: begin
                    mac_clear <= 1'b0;
                    if (term_p0 == LAST_TERM) begin
                        state <= DRAIN;
                    end else begin
                        term_p0 <= term_p0 + 1'b1;
                    end
                end
                DRAIN: begin
                    // Stage p2: MAC absorbed the last term on the preceding negedge
                    mac_clear <= 1'b0;
                    vld_p1    <= 1'b0;
                    res_valid <= 1'b1;
                    res_data  <= shape_result(mac_out);
                    res_idx   <= idx_p0;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Bench for mac_operand_sequencer with sync-read memories, a negedge MAC and a dot-product reference.
module tb_mac_operand_sequencer;

    localparam int AW = 2;
    localparam int NW = 3;
    localparam int N  = 1 << AW;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic                    start = 1'b0;
    logic [NW-1:0]           neuron_idx = '0;
    logic                    busy;
    logic [AW-1:0]           act_addr;
    logic signed [15:0]      act_data;
    logic [NW+AW-1:0]        wt_addr;
    logic signed [7:0]       wt_data;
    logic signed [15:0]      mac_op1;
    logic signed [7:0]       mac_op2;
    logic                    mac_clear;
    logic [15:0]             mac_sum = '0;
    logic                    res_valid;
    logic                    res_ready = 1'b0;
    logic signed [15:0]      res_data;
    logic [NW-1:0]           res_idx;

    logic signed [15:0] act_mem [N];
    logic signed [7:0]  wt_mem  [N << NW];

    int n_checks = 0;
    int n_fail   = 0;
    int clear_cnt = 0;

    mac_operand_sequencer #(.ADDR_W(AW), .NEUR_W(NW)) dut (
        .clk(clk), .reset(reset), .start(start), .neuron_idx(neuron_idx), .busy(busy),
        .act_addr(act_addr), .act_data(act_data), .wt_addr(wt_addr), .wt_data(wt_data),
        .mac_op1(mac_op1), .mac_op2(mac_op2), .mac_clear(mac_clear), .mac_out(mac_sum),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_idx(res_idx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        act_data <= act_mem[act_addr];
        wt_data  <= wt_mem[wt_addr];
    end

    // External multiply-accumulate unit: samples on negedge, clear loads the product
    always @(negedge clk) begin
        mac_sum <= mac_clear ? 16'(int'(mac_op1) * int'(mac_op2))
                             : 16'(int'(mac_sum) + int'(mac_op1) * int'(mac_op2));
        if (mac_clear) clear_cnt <= clear_cnt + 1;
    end

    function automatic logic [15:0] model(input int idx);
        int s;
        logic [15:0] r;
        s = 0;
        for (int k = 0; k < N; k++) s += int'(act_mem[k]) * int'(wt_mem[idx*N + k]);
        r = s[15:0];
`ifdef RELU_EN
        if (r[15]) r = 16'd0;
`endif
        return r;
    endfunction

    task automatic fill(input int a, input int row, input int w);
        for (int k = 0; k < N; k++) begin
            act_mem[k] = 16'(a);
            wt_mem[row*N + k] = 8'(w);
        end
    endtask

    task automatic run_neuron(input logic [NW-1:0] idx, output logic [15:0] data,
                              output logic [NW-1:0] ridx, output int lat);
        start = 1'b1;
        neuron_idx = idx;
        @(posedge clk); #1;
        start = 1'b0;
        neuron_idx = NW'($urandom);
        lat = 1;
        while (!res_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        data = res_data;
        ridx = res_idx;
    endtask

    task automatic handshake;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    task automatic test_reset;
        #2 reset = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_checks++;
        if ({busy, act_addr, wt_addr, mac_op1, mac_op2, mac_clear, res_valid, res_data, res_idx} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: busy=%b addr=%h/%h op=%h/%h clr=%b vld=%b data=%h idx=%h required all 0",
                     busy, act_addr, wt_addr, mac_op1, mac_op2, mac_clear, res_valid, res_data, res_idx);
        end
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        logic [15:0] d; logic [NW-1:0] ri; int lat;
        for (int k = 0; k < N; k++) begin act_mem[k] = 16'(k + 1); wt_mem[k] = 8'sd1; end
        run_neuron(3'd0, d, ri, lat);
        n_checks++;
        if (d !== model(0) || ri !== 3'd0) begin
            n_fail++; $display("FAIL basic_result: got %h idx %0d required %h idx 0", d, ri, model(0));
        end
        n_checks++;
        if (lat !== N + 2) begin
            n_fail++; $display("FAIL basic_latency: got %0d required %0d", lat, N + 2);
        end
        handshake;
    endtask

    task automatic test_negative;
        logic [15:0] d; logic [NW-1:0] ri; int lat;
        fill(-100, 3, 3);
        run_neuron(3'd3, d, ri, lat);
        n_checks++;
        if (d !== model(3) || ri !== 3'd3) begin
            n_fail++; $display("FAIL negative_sum: got %h idx %0d required %h idx 3", d, ri, model(3));
        end
        handshake;
    endtask

    task automatic test_hold;
        logic [15:0] d; logic [NW-1:0] ri; int lat; logic [15:0] exp_d;
        for (int k = 0; k < N; k++) begin act_mem[k] = 16'($urandom); wt_mem[2*N + k] = 8'($urandom); end
        exp_d = model(2);
        run_neuron(3'd2, d, ri, lat);
        n_checks++;
        if (d !== exp_d) begin
            n_fail++; $display("FAIL hold_result: got %h required %h", d, exp_d);
        end
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin start = 1'b1; neuron_idx = 3'd5; end
            @(posedge clk); #1;
            start = 1'b0;
            n_checks++;
            if ({res_valid, busy, res_data, res_idx} !== {1'b1, 1'b1, exp_d, 3'd2}) begin
                n_fail++;
                $display("FAIL hold_stable: vld=%b busy=%b data=%h idx=%0d required 1 1 %h 2",
                         res_valid, busy, res_data, res_idx, exp_d);
            end
        end
        handshake;
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if (busy !== 1'b0 || res_valid !== 1'b0) begin
                n_fail++; $display("FAIL hold_release: busy=%b vld=%b required 0 0", busy, res_valid);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] d0, d1; logic [NW-1:0] r0, r1; int l0, l1; int c0;
        for (int k = 0; k < N; k++) begin act_mem[k] = 16'(k + 1); wt_mem[k] = 8'sd1; wt_mem[N + k] = 8'sd2; end
        c0 = clear_cnt;
        run_neuron(3'd0, d0, r0, l0);
        handshake;
        run_neuron(3'd1, d1, r1, l1);
        handshake;
        n_checks++;
        if (d0 !== model(0) || r0 !== 3'd0 || l0 !== N + 2) begin
            n_fail++; $display("FAIL b2b_first: got %h idx %0d lat %0d required %h 0 %0d", d0, r0, l0, model(0), N + 2);
        end
        n_checks++;
        if (d1 !== model(1) || r1 !== 3'd1 || l1 !== N + 2) begin
            n_fail++; $display("FAIL b2b_second: got %h idx %0d lat %0d required %h 1 %0d", d1, r1, l1, model(1), N + 2);
        end
        n_checks++;
        if (clear_cnt - c0 !== 2) begin
            n_fail++; $display("FAIL b2b_clear_cycles: got %0d required 2", clear_cnt - c0);
        end
    endtask

    task automatic test_reset_abort;
        logic [15:0] d; logic [NW-1:0] ri; int lat;
        for (int k = 0; k < N; k++) begin act_mem[k] = 16'(k + 1); wt_mem[k] = 8'sd1; wt_mem[4*N + k] = 8'sd7; end
        start = 1'b1; neuron_idx = 3'd4;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b1 || mac_op1 === 16'sd0) begin
            n_fail++; $display("FAIL abort_midstream: busy=%b op1=%h required busy 1 with a live term", busy, mac_op1);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if ({busy, act_addr, wt_addr, mac_op1, mac_op2, mac_clear, res_valid, res_data, res_idx} !== '0) begin
            n_fail++;
            $display("FAIL abort_outputs: busy=%b addr=%h/%h op=%h/%h clr=%b vld=%b data=%h idx=%h required all 0",
                     busy, act_addr, wt_addr, mac_op1, mac_op2, mac_clear, res_valid, res_data, res_idx);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        run_neuron(3'd0, d, ri, lat);
        n_checks++;
        if (d !== model(0) || lat !== N + 2) begin
            n_fail++; $display("FAIL abort_recover: got %h lat %0d required %h lat %0d", d, lat, model(0), N + 2);
        end
        handshake;
    endtask

    task automatic test_wrap;
        logic [15:0] d; logic [NW-1:0] ri; int lat; logic [15:0] held;
        fill(32767, 0, 2);
        run_neuron(3'd0, d, ri, lat);
        n_checks++;
        if (d !== model(0)) begin
            n_fail++; $display("FAIL wrap_result: got %h required %h", d, model(0));
        end
        handshake;
        held = mac_sum;
        repeat (5) begin @(posedge clk); #1; end
        n_checks++;
        if (mac_sum !== held) begin
            n_fail++; $display("FAIL idle_mac_stable: got %h required %h", mac_sum, held);
        end
    endtask

    task automatic test_random;
        logic [15:0] d; logic [NW-1:0] ri; int lat; logic [NW-1:0] idx; logic [15:0] exp_d;
        for (int t = 0; t < 8; t++) begin
            for (int k = 0; k < N; k++) act_mem[k] = 16'($urandom);
            for (int k = 0; k < (N << NW); k++) wt_mem[k] = 8'($urandom);
            idx = NW'($urandom);
            exp_d = model(int'(idx));
            run_neuron(idx, d, ri, lat);
            n_checks++;
            if (d !== exp_d || ri !== idx || lat !== N + 2) begin
                n_fail++;
                $display("FAIL random_%0d: got %h idx %0d lat %0d required %h idx %0d lat %0d",
                         t, d, ri, lat, exp_d, idx, N + 2);
            end
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            handshake;
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
    endtask

    initial begin
        for (int k = 0; k < N; k++) act_mem[k] = '0;
        for (int k = 0; k < (N << NW); k++) wt_mem[k] = '0;
        test_reset;
        test_basic;
        test_negative;
        test_hold;
        test_back_to_back;
        test_reset_abort;
        test_wrap;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
